// File: rtl/mesi_isc_arb_pkg.sv
// Shared types and constants for the MESI ISC broadcast arbiter.
// Imported by the picker and the arbiter top.
package mesi_isc_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_RD  = 2'd2;
    localparam logic [1:0] CMD_WB  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/mesi_isc_rr_pick.sv
// Rotating-priority picker: first set bit of mask scanning ptr, ptr+1, ...
// Purely combinational.
module mesi_isc_rr_pick
    import mesi_isc_arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Scan from the far end so the closest-to-ptr hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + ID_W'(i);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_bcast_arbiter.sv
// Four-way arbiter onto the MESI inter-cache broadcast port.
// Round-robin with an aging override, one transaction in flight.
module mesi_isc_bcast_arbiter
    import mesi_isc_arb_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int CMD_W        = 2,
    parameter int STARVE_LIMIT = 16,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*CMD_W-1:0]  cmd_i,
    input  logic [N_REQ*ADDR_W-1:0] addr_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    bus_valid_o,
    output logic [CMD_W-1:0]        bus_cmd_o,
    output logic [ADDR_W-1:0]       bus_addr_o,
    output logic [ID_W-1:0]         bus_id_o,
    input  logic                    bus_ready_i,
    input  logic                    done_i,
    output logic [N_REQ-1:0]        starve_o,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [7:0]        tcnt;
    logic [CNT_W-1:0]  cnt [N_REQ];
    logic [CMD_W-1:0]  cmd_a [N_REQ];
    logic [ADDR_W-1:0] addr_a [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic              s_found;
    logic              e_found;
    logic [ID_W-1:0]   s_idx;
    logic [ID_W-1:0]   e_idx;
    logic [ID_W-1:0]   win;
    logic              start;
    logic              finish;
    logic              busy;

    for (genvar k = 0; k < N_REQ; k++) begin : g_req
        assign cmd_a[k]    = cmd_i[k*CMD_W +: CMD_W];
        assign addr_a[k]   = addr_i[k*ADDR_W +: ADDR_W];
        assign elig[k]     = req_i[k] && (cmd_a[k] != '0);
        assign starve_o[k] = (cnt[k] == CNT_W'(STARVE_LIMIT));
    end

    mesi_isc_rr_pick u_pick_starve (
        .mask  (starve_o & elig),
        .ptr   (rr_ptr),
        .found (s_found),
        .idx   (s_idx)
    );

    mesi_isc_rr_pick u_pick_elig (
        .mask  (elig),
        .ptr   (rr_ptr),
        .found (e_found),
        .idx   (e_idx)
    );

    assign win         = s_found ? s_idx : e_idx;
    assign start       = (state == IDLE) && e_found;
    assign busy        = (state != IDLE);
    assign bus_valid_o = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        err_o     = 1'b0;
        unique case (state)
            IDLE: begin
                if (e_found) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (bus_ready_i) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_i) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else if (tcnt == 8'(DONE_TIMEOUT)) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                    err_o     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            tcnt       <= '0;
            gnt_o      <= '0;
            bus_cmd_o  <= '0;
            bus_addr_o <= '0;
            bus_id_o   <= '0;
        end else begin
            state <= state_nxt;
            gnt_o <= '0;
            if (start) begin
                gnt_o      <= N_REQ'(1) << win;
                bus_id_o   <= win;
                bus_cmd_o  <= cmd_a[win];
                bus_addr_o <= addr_a[win];
            end
            if (state == ISSUE) tcnt <= '0;
            else if (state == WAIT_DONE) tcnt <= tcnt + 8'd1;
            if (finish) rr_ptr <= bus_id_o + ID_W'(1);
        end
    end

    // The in-flight winner neither ages nor clears while it holds its request.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (rst) begin
                cnt[k] <= '0;
            end else if (!elig[k] || (start && win == ID_W'(k))) begin
                cnt[k] <= '0;
            end else if (!(busy && bus_id_o == ID_W'(k)) &&
                         cnt[k] != CNT_W'(STARVE_LIMIT)) begin
                cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mesi_isc_bcast_arbiter.sv
// Scoreboard bench for the MESI ISC broadcast arbiter.
// Expected grants are queued with stimulus and checked when gnt_o fires.
module tb_mesi_isc_bcast_arbiter;

    localparam int TO = 255;

    typedef struct {
        int         id;
        logic [1:0] cmd;
        logic [3:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = '0;
    logic [7:0]  cmd_i = '0;
    logic [15:0] addr_i = '0;
    logic [3:0]  gnt_o;
    logic        bus_valid_o;
    logic [1:0]  bus_cmd_o;
    logic [3:0]  bus_addr_o;
    logic [1:0]  bus_id_o;
    logic        bus_ready_i = 1'b0;
    logic        done_i = 1'b0;
    logic [3:0]  starve_o;
    logic        err_o;

    int   vectors = 0;
    int   errors = 0;
    int   err_cnt = 0;
    exp_t exp_q [$];

    mesi_isc_bcast_arbiter #(
        .ADDR_W(4), .CMD_W(2), .STARVE_LIMIT(16), .DONE_TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .cmd_i       (cmd_i),
        .addr_i      (addr_i),
        .gnt_o       (gnt_o),
        .bus_valid_o (bus_valid_o),
        .bus_cmd_o   (bus_cmd_o),
        .bus_addr_o  (bus_addr_o),
        .bus_id_o    (bus_id_o),
        .bus_ready_i (bus_ready_i),
        .done_i      (done_i),
        .starve_o    (starve_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err_o) err_cnt++;
        if (gnt_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", 32'(gnt_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt", 32'(gnt_o), 32'(4'b1 << e.id));
                check("bus_id", 32'(bus_id_o), 32'(e.id));
                check("bus_cmd", 32'(bus_cmd_o), 32'(e.cmd));
                check("bus_addr", 32'(bus_addr_o), 32'(e.addr));
                check("bus_valid", 32'(bus_valid_o), 32'd1);
            end
        end
    end

    task automatic push(input int id, input logic [1:0] c,
                        input logic [3:0] a);
        exp_t e;
        e.id = id;
        e.cmd = c;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [1:0] c,
                           input logic [3:0] a);
        req_i[k] = 1'b1;
        cmd_i[k*2 +: 2] = c;
        addr_i[k*4 +: 4] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gnt_o != '0) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int dly);
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i = 1'b0;
        repeat (dly - 1) @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
    endtask

    task automatic grant_serve(input int id, input int dly);
        int cyc;
        wait_grant(cyc);
        req_i[id] = 1'b0;
        serve(dly);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_valid"}, 32'(bus_valid_o), 32'd0);
        check({tag, "_cmd"}, 32'(bus_cmd_o), 32'd0);
        check({tag, "_addr"}, 32'(bus_addr_o), 32'd0);
        check({tag, "_id"}, 32'(bus_id_o), 32'd0);
        check({tag, "_starve"}, 32'(starve_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int hit;
        int ngnt;

        // Reset state and a single write
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        push(0, 2'd1, 4'd5);
        set_req(0, 2'd1, 4'd5);
        wait_grant(cyc);
        check("latency", 32'(cyc), 32'd1);
        req_i = '0;
        addr_i[3:0] = 4'd9;
        serve(1);
        check("addr_stable", 32'(bus_addr_o), 32'd5);
        check("idle_valid", 32'(bus_valid_o), 32'd0);

        // Four readers, continuous: plain round-robin
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 2'd2, 4'(k + 1));
        for (int k = 0; k < 4; k++) push(k, 2'd2, 4'(k + 1));
        push(0, 2'd2, 4'd1);
        for (int i = 0; i < 5; i++) begin
            wait_grant(cyc);
            if (i == 4) req_i = '0;
            check("rr_no_starve", 32'(starve_o), 32'd0);
            serve(2);
        end

        // Aging override: starving 0 beats rr_ptr=2
        do_reset();
        push(1, 2'd1, 4'd3);
        set_req(1, 2'd1, 4'd3);
        wait_grant(cyc);
        req_i[1] = 1'b0;
        set_req(0, 2'd1, 4'd7);
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i = 1'b0;
        repeat (20) @(negedge clk);
        set_req(2, 2'd2, 4'd2);
        set_req(3, 2'd3, 4'd4);
        repeat (3) @(negedge clk);
        check("starve_mask", 32'(starve_o), 32'b0001);
        push(0, 2'd1, 4'd7);
        push(2, 2'd2, 4'd2);
        push(3, 2'd3, 4'd4);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        grant_serve(0, 1);
        grant_serve(2, 1);
        grant_serve(3, 1);

        // NOP requests are never granted and never age
        req_i = 4'b1111;
        cmd_i = '0;
        ngnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt_o != '0) ngnt++;
        end
        check("nop_gnt", 32'(ngnt), 32'd0);
        check("nop_starve", 32'(starve_o), 32'd0);
        req_i = '0;

        // Done timeout: err after TO cycles, then winner+1 goes first
        err_cnt = 0;
        push(2, 2'd1, 4'hA);
        set_req(2, 2'd1, 4'hA);
        wait_grant(cyc);
        req_i[2] = 1'b0;
        bus_ready_i = 1'b1;
        hit = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            bus_ready_i = 1'b0;
            if (k == 250) begin
                push(3, 2'd2, 4'hE);
                push(0, 2'd2, 4'h6);
                set_req(0, 2'd2, 4'h6);
                set_req(3, 2'd2, 4'hE);
            end
            if (err_o) begin
                hit = k;
                break;
            end
        end
        check("timeout_cycles", 32'(hit - 1), 32'(TO));
        grant_serve(3, 1);
        grant_serve(0, 1);
        check("err_pulses", 32'(err_cnt), 32'd1);

        // Reset in WAIT_DONE abandons the transaction
        err_cnt = 0;
        push(2, 2'd2, 4'hB);
        set_req(2, 2'd2, 4'hB);
        wait_grant(cyc);
        req_i[2] = 1'b0;
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check("late_done_valid", 32'(bus_valid_o), 32'd0);
        check("late_done_gnt", 32'(gnt_o), 32'd0);
        push(1, 2'd1, 4'hC);
        push(3, 2'd2, 4'hD);
        set_req(1, 2'd1, 4'hC);
        set_req(3, 2'd2, 4'hD);
        grant_serve(1, 1);
        grant_serve(3, 1);
        check("midrst_err", 32'(err_cnt), 32'd0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
